// File: rtl/moore_state_register.sv
// moore_state_register
// Current-state register for a Moore machine, with transition tracking.
// Ports:
//   inputClk        clock, all updates on the rising edge
//   inputR          synchronous reset, active-low
//   inputEn         load enable (0 = hold)
//   inputNext       next-state code from the next-state logic
//   inputHistSel    history read index (0 = most recently departed state)
//   outputState     current state (registered)
//   outputPrev      state held before the last transition (registered)
//   outputChanged   one-cycle pulse after a transition (registered)
//   outputDwell     saturating cycles-in-state counter (registered)
//   outputHist      history entry at inputHistSel (combinational read)
//   outputHistValid selected entry written since reset (combinational read)
module moore_state_register #(
   parameter int unsigned           WIDTH       = 3,
   parameter logic [WIDTH-1:0]      RESET_STATE = '0,
   parameter int unsigned           DEPTH       = 4,
   parameter int unsigned           CNT_WIDTH   = 4,
   parameter int unsigned           SEL_WIDTH   = $clog2(DEPTH)
) (
   input  logic                 inputClk,
   input  logic                 inputR,
   input  logic                 inputEn,
   input  logic [WIDTH-1:0]     inputNext,
   input  logic [SEL_WIDTH-1:0] inputHistSel,
   output logic [WIDTH-1:0]     outputState,
   output logic [WIDTH-1:0]     outputPrev,
   output logic                 outputChanged,
   output logic [CNT_WIDTH-1:0] outputDwell,
   output logic [WIDTH-1:0]     outputHist,
   output logic                 outputHistValid
);

   localparam int unsigned          FILL_WIDTH = $clog2(DEPTH + 1);
   localparam logic [FILL_WIDTH-1:0] FILL_MAX  = FILL_WIDTH'(DEPTH);
   localparam logic [CNT_WIDTH-1:0]  DWELL_MAX = '1;

   logic [WIDTH-1:0]      histQ [DEPTH];
   logic [FILL_WIDTH-1:0] fillCount;
   logic                  transition;

   // A reload of the current code is not a transition.
   assign transition = inputEn && (inputNext != outputState);

   // State, tracking registers and history shift register.
   always_ff @(posedge inputClk) begin
      if (!inputR) begin
         outputState   <= RESET_STATE;
         outputPrev    <= RESET_STATE;
         outputChanged <= 1'b0;
         outputDwell   <= '0;
         fillCount     <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            histQ[i] <= RESET_STATE;
         end
      end else begin
         outputChanged <= transition;
         if (transition) begin
            outputState <= inputNext;
            outputPrev  <= outputState;
            outputDwell <= '0;
            histQ[0]    <= outputState;
            for (int unsigned i = 1; i < DEPTH; i++) begin
               histQ[i] <= histQ[i-1];
            end
            if (fillCount != FILL_MAX) begin
               fillCount <= fillCount + FILL_WIDTH'(1);
            end
         end else if (outputDwell != DWELL_MAX) begin
            outputDwell <= outputDwell + CNT_WIDTH'(1);
         end
      end
   end

   // History read; out-of-range selects read as empty.
   always_comb begin
      outputHist      = '0;
      outputHistValid = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (32'(inputHistSel) == i) begin
            outputHist      = histQ[i];
            outputHistValid = (32'(inputHistSel) < 32'(fillCount));
         end
      end
   end

endmodule

// File: tb/tb_moore_state_register.sv
module tb_moore_state_register;

   logic       clk = 1'b0;
   logic       inputR, inputEn;
   logic [2:0] inputNext;
   logic [1:0] inputHistSel;
   logic [2:0] outputState, outputPrev, outputHist;
   logic       outputChanged, outputHistValid;
   logic [3:0] outputDwell;

   int checks = 0;
   int failures = 0;

   // Reference model: departed states since reset kept newest-first.
   logic [2:0] mState, mPrev;
   logic       mChanged;
   int         mDwell;
   logic [2:0] mHist[$];

   always #5 clk = ~clk;

   moore_state_register #(
      .WIDTH(3), .RESET_STATE(3'b101), .DEPTH(4), .CNT_WIDTH(4), .SEL_WIDTH(2)
   ) dut (
      .inputClk(clk), .inputR(inputR), .inputEn(inputEn), .inputNext(inputNext),
      .inputHistSel(inputHistSel), .outputState(outputState), .outputPrev(outputPrev),
      .outputChanged(outputChanged), .outputDwell(outputDwell), .outputHist(outputHist),
      .outputHistValid(outputHistValid)
   );

   function automatic logic [2:0] expHist(input int sel);
      return (sel < mHist.size()) ? mHist[sel] : 3'b101;
   endfunction

   task automatic tick(input logic r, input logic en, input logic [2:0] nxt);
      inputR = r; inputEn = en; inputNext = nxt;
      @(posedge clk);
      if (!r) begin
         mState = 3'b101; mPrev = 3'b101; mChanged = 1'b0; mDwell = 0;
         mHist.delete();
      end else if (en && nxt != mState) begin
         mHist.push_front(mState);
         if (mHist.size() > 4) void'(mHist.pop_back());
         mPrev = mState; mState = nxt; mChanged = 1'b1; mDwell = 0;
      end else begin
         mChanged = 1'b0;
         mDwell = (mDwell < 15) ? mDwell + 1 : 15;
      end
      #1;
   endtask

   task automatic test_reset();
      tick(1'b0, 1'b1, 3'b010);
      checks++; if (outputState !== 3'd5) begin failures++; $display("FAIL reset_state got=%0d exp=5", outputState); end
      checks++; if (outputPrev !== 3'd5) begin failures++; $display("FAIL reset_prev got=%0d exp=5", outputPrev); end
      checks++; if (outputChanged !== 1'b0) begin failures++; $display("FAIL reset_changed got=%b exp=0", outputChanged); end
      checks++; if (outputDwell !== 4'd0) begin failures++; $display("FAIL reset_dwell got=%0d exp=0", outputDwell); end
      for (int s = 0; s < 4; s++) begin
         inputHistSel = 2'(s); #1;
         checks++; if (outputHistValid !== 1'b0) begin failures++; $display("FAIL reset_valid sel=%0d got=%b exp=0", s, outputHistValid); end
      end
   endtask

   task automatic test_transitions();
      logic [2:0] seq [3] = '{3'd1, 3'd2, 3'd3};
      logic [2:0] hx  [3] = '{3'd2, 3'd1, 3'd5};
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 1'b1, seq[i]);
         checks++; if (outputState !== seq[i]) begin failures++; $display("FAIL trans_state i=%0d got=%0d exp=%0d", i, outputState, seq[i]); end
         checks++; if (outputChanged !== 1'b1) begin failures++; $display("FAIL trans_changed i=%0d got=%b exp=1", i, outputChanged); end
      end
      checks++; if (outputPrev !== 3'd2) begin failures++; $display("FAIL trans_prev got=%0d exp=2", outputPrev); end
      for (int s = 0; s < 4; s++) begin
         inputHistSel = 2'(s); #1;
         if (s < 3) begin
            checks++; if (outputHist !== hx[s]) begin failures++; $display("FAIL trans_hist sel=%0d got=%0d exp=%0d", s, outputHist, hx[s]); end
         end
         checks++; if (outputHistValid !== (s < 3)) begin failures++; $display("FAIL trans_valid sel=%0d got=%b exp=%b", s, outputHistValid, s < 3); end
      end
   endtask

   task automatic test_overflow();
      logic [2:0] seq [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6};
      logic [2:0] hx  [4] = '{3'd4, 3'd3, 3'd2, 3'd1};
      tick(1'b0, 1'b0, 3'd0);
      for (int i = 0; i < 6; i++) tick(1'b1, 1'b1, seq[i]);
      for (int s = 0; s < 4; s++) begin
         inputHistSel = 2'(s); #1;
         checks++; if (outputHist !== hx[s]) begin failures++; $display("FAIL ovf_hist sel=%0d got=%0d exp=%0d", s, outputHist, hx[s]); end
         checks++; if (outputHistValid !== 1'b1) begin failures++; $display("FAIL ovf_valid sel=%0d got=%b exp=1", s, outputHistValid); end
      end
   endtask

   task automatic test_hold_reload();
      logic [2:0] hx [4] = '{3'd4, 3'd3, 3'd2, 3'd1};
      for (int i = 0; i < 20; i++) begin
         tick(1'b1, 1'b0, 3'($urandom));
         checks++; if (outputChanged !== 1'b0) begin failures++; $display("FAIL hold_changed cyc=%0d got=%b exp=0", i, outputChanged); end
         checks++; if (int'(outputDwell) !== ((i + 1 < 15) ? i + 1 : 15)) begin failures++; $display("FAIL hold_dwell cyc=%0d got=%0d exp=%0d", i, outputDwell, (i + 1 < 15) ? i + 1 : 15); end
      end
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 1'b1, 3'd6);
         checks++; if (outputChanged !== 1'b0) begin failures++; $display("FAIL reload_changed got=%b exp=0", outputChanged); end
         checks++; if (outputDwell !== 4'd15) begin failures++; $display("FAIL reload_dwell got=%0d exp=15", outputDwell); end
         checks++; if (outputState !== 3'd6 || outputPrev !== 3'd4) begin failures++; $display("FAIL reload_state got=%0d/%0d exp=6/4", outputState, outputPrev); end
      end
      for (int s = 0; s < 4; s++) begin
         inputHistSel = 2'(s); #1;
         checks++; if (outputHist !== hx[s]) begin failures++; $display("FAIL reload_hist sel=%0d got=%0d exp=%0d", s, outputHist, hx[s]); end
      end
   endtask

   task automatic test_reset_mid();
      tick(1'b0, 1'b1, 3'd3);
      checks++; if (outputState !== 3'd5) begin failures++; $display("FAIL rmid_state got=%0d exp=5", outputState); end
      for (int s = 0; s < 4; s++) begin
         inputHistSel = 2'(s); #1;
         checks++; if (outputHist !== 3'd5 || outputHistValid !== 1'b0) begin failures++; $display("FAIL rmid_hist sel=%0d got=%0d/%b exp=5/0", s, outputHist, outputHistValid); end
      end
      tick(1'b1, 1'b1, 3'd3);
      inputHistSel = 2'd0; #1;
      checks++; if (outputChanged !== 1'b1) begin failures++; $display("FAIL rmid_changed got=%b exp=1", outputChanged); end
      checks++; if (outputHist !== 3'd5 || outputHistValid !== 1'b1) begin failures++; $display("FAIL rmid_hist0 got=%0d/%b exp=5/1", outputHist, outputHistValid); end
      inputHistSel = 2'd1; #1;
      checks++; if (outputHistValid !== 1'b0) begin failures++; $display("FAIL rmid_valid1 got=%b exp=0", outputHistValid); end
   endtask

   task automatic test_enable_gating();
      for (int i = 0; i < 8; i++) begin
         tick(1'b1, 1'b0, (i % 2 == 0) ? 3'd0 : 3'd7);
         checks++; if (outputState !== 3'd3) begin failures++; $display("FAIL gate_state cyc=%0d got=%0d exp=3", i, outputState); end
         checks++; if (outputChanged !== 1'b0) begin failures++; $display("FAIL gate_changed cyc=%0d got=%b exp=0", i, outputChanged); end
         checks++; if (int'(outputDwell) !== i + 1) begin failures++; $display("FAIL gate_dwell cyc=%0d got=%0d exp=%0d", i, outputDwell, i + 1); end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         tick(($urandom_range(0, 29) != 0), ($urandom_range(0, 3) != 0), 3'($urandom));
         inputHistSel = 2'($urandom); #1;
         checks++;
         if (outputState !== mState || outputPrev !== mPrev || outputChanged !== mChanged ||
             int'(outputDwell) !== mDwell) begin
            failures++;
            $display("FAIL rand_regs cyc=%0d got=%0d/%0d/%b/%0d exp=%0d/%0d/%b/%0d", i,
                     outputState, outputPrev, outputChanged, outputDwell, mState, mPrev, mChanged, mDwell);
         end
         checks++;
         if (outputHist !== expHist(int'(inputHistSel)) || outputHistValid !== (int'(inputHistSel) < mHist.size())) begin
            failures++;
            $display("FAIL rand_hist cyc=%0d sel=%0d got=%0d/%b exp=%0d/%b", i, inputHistSel,
                     outputHist, outputHistValid, expHist(int'(inputHistSel)), int'(inputHistSel) < mHist.size());
         end
      end
   endtask

   initial begin
      inputR = 1'b0; inputEn = 1'b0; inputNext = '0; inputHistSel = '0;
      test_reset();
      test_transitions();
      test_overflow();
      test_hold_reload();
      test_reset_mid();
      test_enable_gating();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/moore_state_register.md
# moore_state_register

Parametrised state register for the team's Moore machines: holds a WIDTH-bit current state, loads the next-state code from the combinational next-state logic on each enabled rising clock edge, and resets synchronously to a configurable state. It also tracks state transitions: a one-cycle change pulse, the previous state, a saturating dwell counter and a DEPTH-entry history of departed states. It sits between the next-state logic and the output logic of each Moore machine.

## Interface
- WIDTH, 3: state code width in bits (≥1)
- RESET_STATE, 0: state code loaded on reset (WIDTH bits)
- DEPTH, 4: history entries (≥2)
- CNT_WIDTH, 4: dwell counter width (≥1)
- SEL_WIDTH, $clog2(DEPTH): history select width
---
- Clock and reset: one clock; reset is synchronous and active-low.
- inputClk  in  1  clock; all state updates on the rising edge
- inputR  in  1  synchronous reset, active-low; sampled only on the rising edge of inputClk
- inputEn  in  1  load enable; 0 = hold state
- inputNext  in  WIDTH  next-state code
- inputHistSel  in  SEL_WIDTH  history read index; 0 = most recently departed state
- outputState  out  WIDTH  current state (registered)
- outputPrev  out  WIDTH  state held before the last transition (registered)
- outputChanged  out  1  high for one cycle after a transition (registered)
- outputDwell  out  CNT_WIDTH  cycles since entering the current state, saturating (registered)
- outputHist  out  WIDTH  history entry at inputHistSel (combinational read)
- outputHistValid  out  1  selected entry has been written since reset

## Operation
- Reset (inputR=0 at the edge) overrides everything, including inputEn:
  - outputState, outputPrev and all history entries = RESET_STATE
  - outputChanged=0, outputDwell=0, fill count=0
  - Reset asserted mid-transition discards that transition.
- Transition (inputR=1, inputEn=1, inputNext≠outputState):
  - state<=inputNext; prev<=old state; changed<=1; dwell<=0
  - history shifts: hist[0]<=old state, hist[i]<=hist[i-1]; the oldest entry is dropped
  - fill<=min(fill+1, DEPTH)
- Reload of the same code (inputEn=1, inputNext=outputState): not a transition. Changed<=0, dwell increments, prev and history unchanged.
- Hold (inputEn=0): state, prev, history and fill unchanged; changed<=0; dwell increments.
- Dwell saturates at 2^CNT_WIDTH−1 and never wraps.
- History read:
  - outputHist = hist[inputHistSel]
  - outputHistValid = (inputHistSel < fill)
  - inputHistSel ≥ DEPTH → outputHist=0, outputHistValid=0
- Outputs have no X after the first reset edge. Outputs before the first reset are undefined.

## Timing
- Load latency is one cycle: inputNext sampled at edge k appears on outputState after edge k.
- outputChanged, outputPrev, outputDwell=0 and the new hist[0] all update on that same edge as outputState.
- outputChanged is never high for two consecutive cycles unless two consecutive enabled edges both carry a different code. In that case it stays high for both cycles.
- inputR and inputEn are sampled only at the rising edge; mid-cycle glitches have no effect.
- The history read path is purely combinational from inputHistSel and the registered history. It adds no latency.

## Test plan
All scenarios use WIDTH=3, DEPTH=4, CNT_WIDTH=4 and RESET_STATE=3'b101.
- Reset: inputR=0 for one edge with inputEn=1, inputNext=3'b010 → outputState=5, outputPrev=5, outputChanged=0, outputDwell=0, outputHistValid=0 for every select value.
- Transition sequence: load 1, 2, 3 on consecutive enabled edges → states 1/2/3, with outputChanged high for each of the 3 cycles. Then outputPrev=2 and hist[0..2]=2,1,5; outputHistValid is 1 for select 0–2 and 0 for select 3.
- History overflow: six transitions 0,1,2,3,4,6 after reset → hist[0..3]=4,3,2,1; outputHistValid=1 for all 4 entries; the initial state 5 has been dropped.
- Hold and same-code reload: hold with inputEn=0 for 20 cycles, then inputEn=1 with inputNext equal to the current state → outputChanged stays 0, outputDwell saturates at 15, and history is unchanged.
- Reset mid-operation: inputR=0 on the same edge as inputEn=1 with inputNext=3'b011 → outputState=5, history cleared, fill=0. The next enabled load of 3 produces outputChanged=1 and hist[0]=5.
- Enable gating: inputEn=0 with inputNext toggling on every cycle for 8 cycles → outputState is constant, outputChanged=0, and outputDwell counts 1..8.
